// File: rtl/spi_mem_pkg.sv
// Shared constants and types for the SPI memory path.
// Holds command opcodes, phase widths, FSM encoding and a length clamp.
package spi_mem_pkg;

  localparam logic [7:0] FLASH_READ_CMD = 8'h03;
  localparam logic [7:0] RAM_READ_CMD   = 8'h03;
  localparam logic [7:0] RAM_WRITE_CMD  = 8'h02;

  localparam int CMD_ADDR_BITS = 32;
  localparam int MAX_DATA_BITS = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_FINISH
  } xfer_state_e;

  function automatic logic [5:0] clamp_len(
    input logic [5:0] len
  );
    return (len > 6'(MAX_DATA_BITS)) ?
      6'(MAX_DATA_BITS) : len;
  endfunction

endpackage

// File: rtl/spi_xfer_engine_if.sv
// Start/done handshake between memory controller and SPI engine.
// master = memory controller, slave = spi_xfer_engine.
interface spi_xfer_engine_if;

  logic        start;
  logic        write_enable;
  logic [31:0] cmd_addr;
  logic [5:0]  data_len;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        done;
  logic        busy;

  modport master (
    output start,
    output write_enable,
    output cmd_addr,
    output data_len,
    output data_in,
    input  data_out,
    input  done,
    input  busy
  );

  modport slave (
    input  start,
    input  write_enable,
    input  cmd_addr,
    input  data_len,
    input  data_in,
    output data_out,
    output done,
    output busy
  );

endinterface

// File: rtl/spi_sclk_div.sv
// SCLK half-period counter: phase_end_o marks the last cycle of a phase.
// Ports: clk, rst_n, en_i (LOW/HIGH active), phase_end_o.
module spi_sclk_div #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic phase_end_o
);

  localparam int W =
    (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign phase_end_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (!en_i || phase_end_o)
      cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_xfer_engine.sv
// SPI mode-0 engine: 32-bit cmd/addr phase then up to 32 data bits.
// Ports: clk, rst_n, host (handshake), spi_clk/cs_n/mosi out, spi_miso in.
module spi_xfer_engine
  import spi_mem_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  spi_xfer_engine_if.slave   host,
  output logic               spi_clk,
  output logic               spi_cs_n,
  output logic               spi_mosi,
  input  logic               spi_miso
);

  xfer_state_e state_q, state_d;

  logic [63:0] sr_q, sr_d;
  logic [31:0] rx_q, rx_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [5:0]  len_q, len_d;
  logic        we_q, we_d;
  logic        sclk_q, sclk_d;
  logic        csn_q, csn_d;
  logic        mosi_q, mosi_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;

  logic        phase_end;
  logic        is_data;
  logic [5:0]  len_c;

  spi_sclk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (state_q == ST_LOW ||
                  state_q == ST_HIGH),
    .phase_end_o (phase_end)
  );

  // Counter runs N..1; the last len values are data bits.
  assign is_data = cnt_q <= {1'b0, len_q};
  assign len_c   = clamp_len(host.data_len);

  always_ff @(posedge clk) begin
    if (!rst_n)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (host.start) state_d = ST_LOW;
      ST_LOW:
        if (phase_end) state_d = ST_HIGH;
      ST_HIGH:
        if (phase_end)
          state_d = (cnt_q == 7'd1) ?
            ST_FINISH : ST_LOW;
      ST_FINISH:
        state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sr_d   = sr_q;
    rx_d   = rx_q;
    cnt_d  = cnt_q;
    len_d  = len_q;
    we_d   = we_q;
    sclk_d = sclk_q;
    csn_d  = csn_q;
    mosi_d = mosi_q;
    done_d = 1'b0;
    busy_d = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        csn_d  = 1'b1;
        sclk_d = 1'b0;
        mosi_d = 1'b0;
        busy_d = host.start;
        if (host.start) begin
          // Read data phase shifts out zeros.
          sr_d   = {host.cmd_addr,
                    host.write_enable ?
                    host.data_in : 32'h0};
          cnt_d  = 7'd32 + {1'b0, len_c};
          len_d  = len_c;
          we_d   = host.write_enable;
          rx_d   = '0;
          csn_d  = 1'b0;
          mosi_d = host.cmd_addr[31];
        end
      end
      ST_LOW:
        if (phase_end) sclk_d = 1'b1;
      ST_HIGH:
        if (phase_end) begin
          sclk_d = 1'b0;
          cnt_d  = cnt_q - 7'd1;
          if (!we_q && is_data)
            rx_d = {rx_q[30:0], spi_miso};
          if (cnt_q != 7'd1) begin
            sr_d   = sr_q << 1;
            mosi_d = sr_q[62];
          end
        end
      ST_FINISH: begin
        csn_d  = 1'b1;
        done_d = 1'b1;
        mosi_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q   <= '0;
      rx_q   <= '0;
      cnt_q  <= '0;
      len_q  <= '0;
      we_q   <= 1'b0;
      sclk_q <= 1'b0;
      csn_q  <= 1'b1;
      mosi_q <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      rx_q   <= rx_d;
      cnt_q  <= cnt_d;
      len_q  <= len_d;
      we_q   <= we_d;
      sclk_q <= sclk_d;
      csn_q  <= csn_d;
      mosi_q <= mosi_d;
      done_q <= done_d;
      busy_q <= busy_d;
    end
  end

  assign host.data_out = rx_q;
  assign host.done     = done_q;
  assign host.busy     = busy_q;
  assign spi_clk       = sclk_q;
  assign spi_cs_n      = csn_q;
  assign spi_mosi      = mosi_q;

endmodule

// File: tb/tb_spi_xfer_engine.sv
// Directed bench for spi_xfer_engine with CLK_DIV=1 and CLK_DIV=2 copies.
// Table of transfers plus reset-abort and held-start sequences.
module tb_spi_xfer_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        start_r = 1'b0;
  logic        we_r = 1'b0;
  logic [31:0] cmd_r = '0;
  logic [31:0] din_r = '0;
  logic [5:0]  len_r = '0;

  spi_xfer_engine_if if1 ();
  spi_xfer_engine_if if2 ();

  assign if1.start        = start_r & ~sel;
  assign if2.start        = start_r & sel;
  assign if1.write_enable = we_r;
  assign if2.write_enable = we_r;
  assign if1.cmd_addr     = cmd_r;
  assign if2.cmd_addr     = cmd_r;
  assign if1.data_len     = len_r;
  assign if2.data_len     = len_r;
  assign if1.data_in      = din_r;
  assign if2.data_in      = din_r;

  logic sclk1, csn1, mosi1;
  logic sclk2, csn2, mosi2;
  logic miso;

  spi_xfer_engine #(.CLK_DIV(1)) u_d1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .host     (if1.slave),
    .spi_clk  (sclk1),
    .spi_cs_n (csn1),
    .spi_mosi (mosi1),
    .spi_miso (miso)
  );

  spi_xfer_engine #(.CLK_DIV(2)) u_d2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .host     (if2.slave),
    .spi_clk  (sclk2),
    .spi_cs_n (csn2),
    .spi_mosi (mosi2),
    .spi_miso (miso)
  );

  wire        sclk = sel ? sclk2 : sclk1;
  wire        csn  = sel ? csn2 : csn1;
  wire        mosi = sel ? mosi2 : mosi1;
  wire        done = sel ? if2.done : if1.done;
  wire        busy = sel ? if2.busy : if1.busy;
  wire [31:0] dout = sel ? if2.data_out : if1.data_out;

  // Mode-0 slave: first bit valid at CS fall, next after each SCLK fall.
  logic [63:0] sl_sr = '0;
  assign miso = sl_sr[63];
  always @(negedge sclk) sl_sr = {sl_sr[62:0], 1'b0};

  logic [63:0] mcap = '0;
  int nrise = 0;
  always @(posedge sclk)
    if (!csn) begin
      mcap = {mcap[62:0], mosi};
      nrise++;
    end

  int ndone = 0;
  always @(negedge clk) if (done) ndone++;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  typedef struct {
    logic        sel;
    logic        we;
    logic [31:0] cmd;
    logic [5:0]  len;
    logic [31:0] din;
    logic [63:0] slv;
    int          cyc;
    int          rises;
    logic [63:0] mosi;
    logic [31:0] dout;
  } vec_t;

  vec_t v[7];

  task automatic run_vec(input vec_t t, input int id);
    int k;
    bit got;
    @(negedge clk);
    sel     = t.sel;
    we_r    = t.we;
    cmd_r   = t.cmd;
    len_r   = t.len;
    din_r   = t.din;
    sl_sr   = t.slv;
    mcap    = '0;
    nrise   = 0;
    start_r = 1'b1;
    @(posedge clk);
    #1 start_r = 1'b0;
    k = 0;
    got = 0;
    while (k < 2000 && !got) begin
      @(posedge clk);
      k++;
      #1;
      if (done) got = 1;
    end
    chk($sformatf("v%0d done_cycle", id), k, t.cyc);
    chk($sformatf("v%0d busy_at_done", id), busy, 1);
    chk($sformatf("v%0d cs_n_at_done", id), csn, 1);
    chk($sformatf("v%0d data_out", id), dout, t.dout);
    chk($sformatf("v%0d sclk_rises", id), nrise, t.rises);
    chk($sformatf("v%0d mosi_bits", id), mcap, t.mosi);
    @(posedge clk);
    #1;
    chk($sformatf("v%0d done_1cyc", id), done, 0);
    chk($sformatf("v%0d busy_clear", id), busy, 0);
    chk($sformatf("v%0d dout_hold", id), dout, t.dout);
  endtask

  initial begin
    int k;
    int d0;

    v[0] = '{1'b0, 1'b0, 32'h03000100, 6'd32,
             32'hDEADBEEF, {32'h0, 32'h13000093},
             129, 64, 64'h03000100_00000000,
             32'h13000093};
    v[1] = '{1'b1, 1'b1, 32'h02000010, 6'd8,
             32'hA5000000, 64'hFFFFFFFF_FFFFFFFF,
             161, 40, 64'h00000002_000010A5,
             32'h0};
    v[2] = '{1'b0, 1'b0, 32'h03000200, 6'd16,
             32'h0, {32'h0, 32'h34120000},
             97, 48, 64'h00000300_02000000,
             32'h00003412};
    v[3] = '{1'b0, 1'b0, 32'h0B123456, 6'd0,
             32'h0, 64'hFFFFFFFF_FFFFFFFF,
             65, 32, 64'h00000000_0B123456,
             32'h0};
    v[4] = '{1'b0, 1'b0, 32'h03ABCDEF, 6'd40,
             32'h0, {32'h0, 32'h89ABCDEF},
             129, 64, 64'h03ABCDEF_00000000,
             32'h89ABCDEF};
    v[5] = '{1'b0, 1'b1, 32'h02000020, 6'd32,
             32'h12345678, 64'hFFFFFFFF_FFFFFFFF,
             129, 64, 64'h02000020_12345678,
             32'h0};
    v[6] = '{1'b1, 1'b0, 32'h03000004, 6'd8,
             32'hFFFFFFFF, {32'h0, 32'hC3000000},
             161, 40, 64'h00000003_00000400,
             32'h000000C3};

    repeat (3) @(posedge clk);
    #1;
    chk("rst cs_n", {csn1, csn2}, 2'b11);
    chk("rst sclk", {sclk1, sclk2}, 2'b00);
    chk("rst mosi", {mosi1, mosi2}, 2'b00);
    chk("rst done", {if1.done, if2.done}, 2'b00);
    chk("rst busy", {if1.busy, if2.busy}, 2'b00);
    chk("rst dout", {if1.data_out, if2.data_out}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      run_vec(v[i], i);

    // Reset mid-write after 10 SCLKs.
    @(negedge clk);
    sel = 1'b0;
    we_r = 1'b1;
    cmd_r = 32'h02000000;
    len_r = 6'd32;
    din_r = 32'hFFFFFFFF;
    sl_sr = '0;
    nrise = 0;
    start_r = 1'b1;
    @(posedge clk);
    #1 start_r = 1'b0;
    k = 0;
    while (nrise < 10 && k < 500) begin
      @(posedge clk);
      k++;
    end
    chk("abort reach 10 sclk", nrise >= 10, 1);
    @(negedge clk);
    rst_n = 1'b0;
    d0 = ndone;
    @(posedge clk);
    #1;
    chk("abort cs_n", csn, 1);
    chk("abort sclk", sclk, 0);
    chk("abort busy", busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    chk("abort no done", ndone, d0);
    run_vec(v[0], 10);

    // start held high across two transfers.
    @(negedge clk);
    sel = 1'b0;
    we_r = 1'b0;
    cmd_r = 32'h03000000;
    len_r = 6'd0;
    sl_sr = '0;
    d0 = ndone;
    start_r = 1'b1;
    @(posedge clk);
    k = 0;
    #1;
    while (k < 500 && !done) begin
      @(posedge clk);
      k++;
      #1;
    end
    chk("held first done", k, 65);
    @(posedge clk);
    k++;
    #1;
    chk("held restart cs_n", csn, 0);
    chk("held restart busy", busy, 1);
    while (k < 1000 && !done) begin
      @(posedge clk);
      k++;
      #1;
    end
    start_r = 1'b0;
    chk("held second done", k, 131);
    @(posedge clk);
    #1;
    chk("held busy end", busy, 0);
    repeat (20) @(negedge clk);
    chk("held done count", ndone - d0, 2);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_xfer_engine.md
# spi_xfer_engine

Single-lane SPI mode-0 transfer engine between the memory controller and the shared flash/RAM SPI bus. For each transaction it shifts out a 32-bit command+address word, then either writes up to 32 data bits or reads up to 32 bits from `spi_miso`. It drives one `spi_cs_n`; the memory controller steers that into `flash_cs_n` or `ram_cs_n`. It presents a start/done handshake to the memory controller.

## Interface
- `CLK_DIV`, default 1: system clocks per SCLK half-period; legal values ≥1; SCLK = clk/(2·CLK_DIV).
- `clk` in 1: system clock; all logic on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: one-cycle request; sampled only in IDLE, ignored otherwise.
- `write_enable` in 1: 1 = write data phase, 0 = read data phase; latched at start.
- `cmd_addr` in 32: {cmd[7:0], addr[23:0]}; shifted MSB first; latched at start.
- `data_len` in 6: data-phase bit count 0..32; values >32 clamp to 32; latched at start.
- `data_in` in 32: write data, sent from bit 31 downward; latched at start.
- `data_out` out 32: read bits, right-justified; first received bit is most significant.
- `done` out 1: one-cycle pulse at transaction end.
- `busy` out 1: high from the cycle after start acceptance until the cycle done is high, inclusive.
- `spi_clk` out 1: SCLK, idles low.
- `spi_cs_n` out 1: chip select, active low.
- `spi_mosi` out 1: serial out.
- `spi_miso` in 1: serial in.

## Operation
- States: IDLE, LOW, HIGH, FINISH.
- IDLE: `spi_cs_n`=1, `spi_clk`=0. On `start`:
  - load the shift register with {cmd_addr, data_in};
  - set bit counter N = 32 + min(data_len,32);
  - clear `data_out`;
  - drive `spi_cs_n`=0 and `spi_mosi`=cmd_addr[31];
  - go to LOW.
- LOW: `spi_clk`=0 for CLK_DIV cycles. Then drive `spi_clk`=1 and go to HIGH.
- HIGH: `spi_clk`=1 for CLK_DIV cycles. On the last HIGH cycle:
  - if this is a data-phase bit and the transaction is a read, shift `spi_miso` into `data_out` LSB (data_out <= {data_out[30:0], miso});
  - drive `spi_clk`=0 and decrement N;
  - if N reaches 0, go to FINISH;
  - otherwise shift the register and present the next MOSI bit, then go to LOW.
- MOSI in the read data phase: 0.
- MOSI in the write data phase: data_in[31], data_in[30], and so on.
- Writes ignore `spi_miso`; `data_out` stays 0.
- FINISH: drive `spi_cs_n`=1 and `done`=1 for one cycle, then go to IDLE.
- Result for 8-bit read: received byte in data_out[7:0].
- Result for 32-bit read: first byte in [31:24]; byte reordering is the memory controller's job.
- data_len=0: command/address phase only, 32 SCLKs.

## Timing
- Reset values: `spi_cs_n`=1, `spi_clk`=0, `spi_mosi`=0, `done`=0, `busy`=0, `data_out`=0, state IDLE.
- Reset asserted mid-transaction aborts it on the next edge: CS rises immediately and no `done` is issued.
- Total bits: N = 32 + len.
- `done` is high in the cycle 2·CLK_DIV·N + 1 edges after the `start`-sampling edge.
- Example: CLK_DIV=1, 32-bit read (N=64): done 129 cycles after start.
- MOSI changes only while SCLK is low. It is stable at least CLK_DIV cycles before each rising edge.
- MISO is sampled at the end of the high phase.
- CS-to-first-rising-edge setup: CLK_DIV cycles.
- CS deasserts one cycle after the last falling edge.
- Minimum CS-high time: 1 cycle (FINISH). A `start` arriving in the cycle after `done` is accepted.
- `start` asserted in LOW, HIGH or FINISH is dropped. No queueing.
- `data_out` is valid from the `done` cycle and holds until the next accepted `start`.

## Structure
- Shared package `spi_mem_pkg`:
  - FLASH_READ_CMD=8'h03, RAM_READ_CMD=8'h03, RAM_WRITE_CMD=8'h02;
  - CMD_ADDR_BITS=32, MAX_DATA_BITS=32;
  - state encoding.
- Natural sub-module `spi_sclk_div`: half-period counter producing the `phase_end` strobe for CLK_DIV.
- Everything else lives in the top level: FSM, 64-bit TX shift register, 32-bit RX register, 7-bit bit counter.

## Test plan
- Reset mid-transaction: start a write, assert rst_n=0 after 10 SCLKs → cs_n=1, sclk=0, done never pulses; a fresh start afterwards completes normally.
- Flash read: CLK_DIV=1, cmd_addr=32'h03000100, len=32, write_enable=0, slave returns bytes 13 00 00 93.
  - MOSI shows 03 00 01 00;
  - data_out=32'h13000093;
  - done at cycle 129; exactly 64 SCLK rising edges.
- Byte write: CLK_DIV=2, cmd_addr=32'h02000010, data_in=32'hA5000000, len=8.
  - MOSI shows 02 00 00 10 A5;
  - 40 SCLKs; data_out=0; done at cycle 161.
- Read with data_len=16, slave returns 34 12 → data_out=32'h00003412.
- data_len=0 → 32 SCLKs, done at cycle 65 (CLK_DIV=1).
- data_len=40 → clamped to 32, 64 SCLKs.
- start held high through a whole transaction → second transfer begins the cycle after done; no start accepted while busy.
